pc_fetch_ctrl: RTL and testbench

Fetch-stage controller that sequences the PC register and the instruction-memory port. It drives the PC register's `Keep`/`PC_Next` inputs, issues req/ack fetches at the current PC, and holds instructions under hazard stalls. It also resolves branch, jump and exception redirects, including redirects that arrive while a fetch is outstanding. It sits between the PC register, instruction memory, the hazard unit, and the IF/ID pipeline register.

---
 rtl/pc_fetch_pkg.sv | 18 +
 rtl/pc_fetch_if.sv | 26 ++
 rtl/pc_redirect_sel.sv | 45 ++++
 rtl/pc_fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the fetch-stage controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: fetch FSM state enum, PC reset vector, default exception vector.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        SQUASH = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR       = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch port: request/address out, ack/data back.
// Latency: ack may come in the request cycle or any number of cycles later.
// Backpressure: memory stretches a fetch by withholding imem_ack; req/addr hold until ack.
//
// Signals: imem_req, imem_addr (controller -> memory); imem_ack, imem_rdata (memory -> controller).
// master modport = fetch controller, slave modport = instruction memory.
interface pc_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_redirect_sel.sv
// Priority select over redirect sources: exception > branch > jump.
// Latency: combinational.
// Backpressure: none.
//
// Ports: exc_req (only with PC_FETCH_EXC_EN), br_taken/br_target, jmp_valid/jmp_target in;
// redir (any source active) and redir_target (target of the winning source) out.
// Macro PC_FETCH_EXC_EN adds the exception source and the EXC_VECTOR parameter.
module pc_redirect_sel
    import pc_fetch_pkg::*;
`ifdef PC_FETCH_EXC_EN
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
)
`endif
(
`ifdef PC_FETCH_EXC_EN
    input  logic        exc_req,
`endif
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    output logic        redir,
    output logic [31:0] redir_target
);

    always_comb begin
        redir        = 1'b0;
        redir_target = '0;
`ifdef PC_FETCH_EXC_EN
        if (exc_req) begin
            redir        = 1'b1;
            redir_target = EXC_VECTOR;
        end else
`endif
        if (br_taken) begin
            redir        = 1'b1;
            redir_target = br_target;
        end else if (jmp_valid) begin
            redir        = 1'b1;
            redir_target = jmp_target;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: sequences PC register (keep/pc_next) and the imem port, holds under stall, resolves redirects.
// Latency: 0 cycles with a zero-wait memory (ack in request cycle); one instruction per cycle.
// Backpressure: a withheld ack holds the PC (keep=1); stall parks the fetched word in a hold buffer.
//
// Ports: clk, rst_n (async, active-low); pc/pc4 from PC register; keep/pc_next to PC register;
// stall from hazard unit; br_taken/br_target, jmp_valid/jmp_target, exc_req (PC_FETCH_EXC_EN) redirects;
// imem (pc_fetch_if.master) fetch port; inst/inst_valid/flush to IF/ID register.
// Macro PC_FETCH_EXC_EN enables the exc_req port and the EXC_VECTOR parameter.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
`ifdef PC_FETCH_EXC_EN
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
)
`endif
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pc,
    input  logic [31:0]       pc4,
    output logic              keep,
    output logic [31:0]       pc_next,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    input  logic              jmp_valid,
    input  logic [31:0]       jmp_target,
`ifdef PC_FETCH_EXC_EN
    input  logic              exc_req,
`endif
    pc_fetch_if.master        imem,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic              flush
);

    fetch_state_t state, state_d;
    logic [31:0]  hold_buf, hold_buf_d;
    logic [31:0]  tgt_lat, tgt_lat_d;
    logic         redir;
    logic [31:0]  redir_target;
    logic         req;

    pc_redirect_sel
`ifdef PC_FETCH_EXC_EN
    #(
        .EXC_VECTOR (EXC_VECTOR)
    )
`endif
    u_redirect_sel (
`ifdef PC_FETCH_EXC_EN
        .exc_req      (exc_req),
`endif
        .br_taken     (br_taken),
        .br_target    (br_target),
        .jmp_valid    (jmp_valid),
        .jmp_target   (jmp_target),
        .redir        (redir),
        .redir_target (redir_target)
    );

    // The fetch address is always the live PC; keep=1 pins it while a fetch is outstanding.
    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_buf <= '0;
            tgt_lat  <= '0;
        end else begin
            state    <= state_d;
            hold_buf <= hold_buf_d;
            tgt_lat  <= tgt_lat_d;
        end
    end

    always_comb begin
        state_d    = state;
        hold_buf_d = hold_buf;
        tgt_lat_d  = tgt_lat;
        keep       = 1'b1;
        pc_next    = RESET_VECTOR;
        req        = 1'b0;
        inst       = '0;
        inst_valid = 1'b0;
        flush      = 1'b0;

        unique case (state)
            IDLE: begin
                // Redirects are ignored here: nothing has been fetched yet.
                state_d = FETCH;
            end

            FETCH: begin
                req   = 1'b1;
                flush = redir;
                if (imem.imem_ack) begin
                    if (redir) begin
                        // Fetched word belongs to the wrong path; go straight to the target.
                        keep    = 1'b0;
                        pc_next = redir_target;
                    end else if (stall) begin
                        hold_buf_d = imem.imem_rdata;
                        state_d    = HOLD;
                    end else begin
                        inst       = imem.imem_rdata;
                        inst_valid = 1'b1;
                        keep       = 1'b0;
                        pc_next    = pc4;
                    end
                end else if (redir) begin
                    // The in-flight request cannot be withdrawn; remember where to go once it drains.
                    tgt_lat_d = redir_target;
                    state_d   = SQUASH;
                end
            end

            HOLD: begin
                inst       = hold_buf;
                inst_valid = 1'b1;
                flush      = redir;
                if (redir) begin
                    keep    = 1'b0;
                    pc_next = redir_target;
                    state_d = FETCH;
                end else if (!stall) begin
                    keep    = 1'b0;
                    pc_next = pc4;
                    state_d = FETCH;
                end
            end

            SQUASH: begin
                req   = 1'b1;
                flush = redir;
                if (redir) begin
                    tgt_lat_d = redir_target;
                end
                if (imem.imem_ack) begin
                    keep    = 1'b0;
                    pc_next = redir ? redir_target : tgt_lat;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl with a behavioural PC register.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        keep;
    logic [31:0] pc_next;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        exc_req;
    logic [31:0] inst;
    logic        inst_valid;
    logic        flush;

    int tests;
    int fails;

    pc_fetch_if imem_bus ();

    pc_fetch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .pc4        (pc4),
        .keep       (keep),
        .pc_next    (pc_next),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
`ifdef PC_FETCH_EXC_EN
        .exc_req    (exc_req),
`endif
        .imem       (imem_bus.master),
        .inst       (inst),
        .inst_valid (inst_valid),
        .flush      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register model: independent reset to the reset vector, loads pc_next when keep=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 32'h0040_0000;
        else if (!keep) pc <= pc_next;
    end
    assign pc4 = pc + 32'd4;

    task automatic clear_inputs();
        stall               = 1'b0;
        br_taken            = 1'b0;
        br_target           = '0;
        jmp_valid           = 1'b0;
        jmp_target          = '0;
        exc_req             = 1'b0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = '0;
    endtask

    // Leaves the DUT at a negedge in FETCH with pc = reset vector.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++; if (keep !== 1'b1) begin fails++; $display("FAIL rst_keep got=%0h want=1", keep); end
        tests++; if (pc_next !== 32'h0040_0000) begin fails++; $display("FAIL rst_pc_next got=%08h want=00400000", pc_next); end
        tests++; if (imem_bus.imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got=%0h want=0", imem_bus.imem_req); end
        tests++; if (imem_bus.imem_addr !== 32'h0040_0000) begin fails++; $display("FAIL rst_addr got=%08h want=00400000", imem_bus.imem_addr); end
        tests++; if (inst !== 32'h0) begin fails++; $display("FAIL rst_inst got=%08h want=0", inst); end
        tests++; if (inst_valid !== 1'b0 || flush !== 1'b0) begin fails++; $display("FAIL rst_valid_flush got=%0h/%0h want=0/0", inst_valid, flush); end
        rst_n = 1'b1;
        #1;
        tests++; if (imem_bus.imem_req !== 1'b0) begin fails++; $display("FAIL idle_req got=%0h want=0", imem_bus.imem_req); end
        @(negedge clk);
        #1;
        tests++; if (imem_bus.imem_req !== 1'b1) begin fails++; $display("FAIL first_req got=%0h want=1", imem_bus.imem_req); end
        tests++; if (imem_bus.imem_addr !== 32'h0040_0000) begin fails++; $display("FAIL first_addr got=%08h want=00400000", imem_bus.imem_addr); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] words [3];
        words[0] = 32'h2008_0001;
        words[1] = 32'h2009_0002;
        words[2] = 32'h0109_5020;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            imem_bus.imem_ack   = 1'b1;
            imem_bus.imem_rdata = words[i];
            #1;
            tests++; if (imem_bus.imem_addr !== 32'h0040_0000 + 32'(4*i)) begin fails++; $display("FAIL zw_addr%0d got=%08h want=%08h", i, imem_bus.imem_addr, 32'h0040_0000 + 32'(4*i)); end
            tests++; if (inst_valid !== 1'b1 || inst !== words[i]) begin fails++; $display("FAIL zw_inst%0d got=%0h/%08h want=1/%08h", i, inst_valid, inst, words[i]); end
            tests++; if (keep !== 1'b0 || pc_next !== 32'h0040_0004 + 32'(4*i)) begin fails++; $display("FAIL zw_next%0d got=%0h/%08h want=0/%08h", i, keep, pc_next, 32'h0040_0004 + 32'(4*i)); end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_wait_states();
        do_reset();
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h1111_1111;
        @(negedge clk);
        imem_bus.imem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++; if (keep !== 1'b1 || imem_bus.imem_addr !== 32'h0040_0004) begin fails++; $display("FAIL ws_hold%0d got=%0h/%08h want=1/00400004", i, keep, imem_bus.imem_addr); end
            tests++; if (inst_valid !== 1'b0 || imem_bus.imem_req !== 1'b1) begin fails++; $display("FAIL ws_req%0d got=%0h/%0h want=0/1", i, inst_valid, imem_bus.imem_req); end
            @(negedge clk);
        end
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h1234_5678;
        #1;
        tests++; if (inst_valid !== 1'b1 || inst !== 32'h1234_5678 || keep !== 1'b0) begin fails++; $display("FAIL ws_data got=%0h/%08h/%0h want=1/12345678/0", inst_valid, inst, keep); end
        @(negedge clk);
        imem_bus.imem_ack = 1'b0;
        #1;
        tests++; if (imem_bus.imem_addr !== 32'h0040_0008) begin fails++; $display("FAIL ws_next_addr got=%08h want=00400008", imem_bus.imem_addr); end
        clear_inputs();
    endtask

    task automatic test_stall_hold();
        do_reset();
        imem_bus.imem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        imem_bus.imem_rdata = 32'h8C08_0000;
        stall               = 1'b1;
        #1;
        tests++; if (imem_bus.imem_addr !== 32'h0040_0008 || keep !== 1'b1) begin fails++; $display("FAIL st_capture got=%08h/%0h want=00400008/1", imem_bus.imem_addr, keep); end
        @(negedge clk);
        imem_bus.imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stall = (i < 2);
            #1;
            tests++; if (inst_valid !== 1'b1 || inst !== 32'h8C08_0000 || imem_bus.imem_req !== 1'b0) begin fails++; $display("FAIL st_hold%0d got=%0h/%08h/%0h want=1/8c080000/0", i, inst_valid, inst, imem_bus.imem_req); end
            tests++; if (keep !== (i < 2 ? 1'b1 : 1'b0)) begin fails++; $display("FAIL st_keep%0d got=%0h want=%0h", i, keep, (i < 2 ? 1'b1 : 1'b0)); end
            @(negedge clk);
        end
        #1;
        tests++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0040_000C) begin fails++; $display("FAIL st_resume got=%0h/%08h want=1/0040000c", imem_bus.imem_req, imem_bus.imem_addr); end
        clear_inputs();
    endtask

    task automatic test_squash();
        do_reset();
        br_taken  = 1'b1;
        br_target = 32'h0040_0100;
        #1;
        tests++; if (flush !== 1'b1 || keep !== 1'b1) begin fails++; $display("FAIL sq_flush got=%0h/%0h want=1/1", flush, keep); end
        @(negedge clk);
        br_taken = 1'b0;
        #1;
        tests++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0040_0000 || inst_valid !== 1'b0 || keep !== 1'b1) begin fails++; $display("FAIL sq_wait got=%0h/%08h/%0h/%0h want=1/00400000/0/1", imem_bus.imem_req, imem_bus.imem_addr, inst_valid, keep); end
        @(negedge clk);
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        #1;
        tests++; if (inst_valid !== 1'b0 || keep !== 1'b0 || pc_next !== 32'h0040_0100) begin fails++; $display("FAIL sq_ack got=%0h/%0h/%08h want=0/0/00400100", inst_valid, keep, pc_next); end
        @(negedge clk);
        imem_bus.imem_ack = 1'b0;
        #1;
        tests++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0040_0100) begin fails++; $display("FAIL sq_target got=%0h/%08h want=1/00400100", imem_bus.imem_req, imem_bus.imem_addr); end
        clear_inputs();
    endtask

    task automatic test_priority();
        logic [31:0] want;
`ifdef PC_FETCH_EXC_EN
        want = 32'h8000_0180;
`else
        want = 32'h0040_0200;
`endif
        do_reset();
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hCAFE_0001;
        exc_req    = 1'b1;
        br_taken   = 1'b1;
        br_target  = 32'h0040_0200;
        jmp_valid  = 1'b1;
        jmp_target = 32'h0040_0300;
        #1;
        tests++; if (flush !== 1'b1 || inst_valid !== 1'b0) begin fails++; $display("FAIL pr_flush got=%0h/%0h want=1/0", flush, inst_valid); end
        tests++; if (keep !== 1'b0 || pc_next !== want) begin fails++; $display("FAIL pr_target got=%0h/%08h want=0/%08h", keep, pc_next, want); end
        @(negedge clk);
        exc_req  = 1'b0;
        br_taken = 1'b0;
        #1;
        tests++; if (imem_bus.imem_addr !== want) begin fails++; $display("FAIL pr_fetch got=%08h want=%08h", imem_bus.imem_addr, want); end
        tests++; if (pc_next !== 32'h0040_0300 || flush !== 1'b1) begin fails++; $display("FAIL pr_jmp got=%08h/%0h want=00400300/1", pc_next, flush); end
        @(negedge clk);
        jmp_valid = 1'b0;
        #1;
        tests++; if (imem_bus.imem_addr !== 32'h0040_0300 || inst_valid !== 1'b1) begin fails++; $display("FAIL pr_jmp_fetch got=%08h/%0h want=00400300/1", imem_bus.imem_addr, inst_valid); end
        clear_inputs();
    endtask

    task automatic test_reset_in_squash();
        do_reset();
        jmp_valid  = 1'b1;
        jmp_target = 32'h0040_0400;
        @(negedge clk);
        jmp_valid = 1'b0;
        #1;
        tests++; if (imem_bus.imem_req !== 1'b1 || keep !== 1'b1) begin fails++; $display("FAIL rs_squash got=%0h/%0h want=1/1", imem_bus.imem_req, keep); end
        rst_n = 1'b0;
        #1;
        tests++; if (imem_bus.imem_req !== 1'b0 || keep !== 1'b1 || pc_next !== 32'h0040_0000 || inst_valid !== 1'b0 || flush !== 1'b0) begin fails++; $display("FAIL rs_async got=%0h/%0h/%08h/%0h/%0h want=0/1/00400000/0/0", imem_bus.imem_req, keep, pc_next, inst_valid, flush); end
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++; if (inst_valid !== 1'b0 || imem_bus.imem_req !== 1'b0 || keep !== 1'b1) begin fails++; $display("FAIL rs_late_ack got=%0h/%0h/%0h want=0/0/1", inst_valid, imem_bus.imem_req, keep); end
        @(negedge clk);
        imem_bus.imem_rdata = 32'h0000_0013;
        #1;
        tests++; if (imem_bus.imem_addr !== 32'h0040_0000 || inst !== 32'h0000_0013 || pc_next !== 32'h0040_0004) begin fails++; $display("FAIL rs_refetch got=%08h/%08h/%08h want=00400000/00000013/00400004", imem_bus.imem_addr, inst, pc_next); end
        clear_inputs();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_hold();
        test_squash();
        test_priority();
        test_reset_in_squash();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
